// File: rtl/regfile_pkg.sv
// Shared register-file constants: default geometry, address-width helper
// and the hard-wired zero register index.
package regfile_pkg;

  localparam int BITS_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus into the multi-port register file.
// Flat vectors, port p occupies [p*W +: W].
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) ();

  localparam int AW = addr_w(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*BITS-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*BITS-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                busy_any;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output sb_set, sb_addr,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  sb_set, sb_addr,
    output rd_data, rd_busy, busy_any
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: writes clear, decode issue sets, set wins.
// Exposes next-state vector so reads see the post-edge busy state.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2,
  parameter int AW    = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              sb_set_i,
  input  logic [AW-1:0]     sb_addr_i,
  output logic [NREGS-1:0]  busy_d_o,
  output logic              busy_any_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             busy_any_q;

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == AW'(r))
          busy_d[r] = 1'b0;
      end
      if (sb_set_i && sb_addr_i == AW'(r))
        busy_d[r] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
    end
  end

  assign busy_d_o   = busy_d;
  assign busy_any_o = busy_any_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-first bypass,
// higher-index write priority and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  localparam int AW = addr_w(NREGS);

  logic [BITS-1:0]     mem_q [NREGS];
  logic [NRD*BITS-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]      rd_busy_q, rd_busy_d;
  logic [NREGS-1:0]    busy_d;
  logic                busy_any;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .sb_set_i   (bus.sb_set),
    .sb_addr_i  (bus.sb_addr),
    .busy_d_o   (busy_d),
    .busy_any_o (busy_any)
  );

  // Later ports overwrite earlier ones, giving the higher index priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        mem_q[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] &&
            bus.wr_addr[w*AW +: AW] != AW'(REG_ZERO))
          mem_q[bus.wr_addr[w*AW +: AW]] <=
            bus.wr_data[w*BITS +: BITS];
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data_d[p*BITS +: BITS] =
        mem_q[bus.rd_addr[p*AW +: AW]];
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] &&
            bus.wr_addr[w*AW +: AW] == bus.rd_addr[p*AW +: AW])
          rd_data_d[p*BITS +: BITS] =
            bus.wr_data[w*BITS +: BITS];
      end
      if (bus.rd_addr[p*AW +: AW] == AW'(REG_ZERO))
        rd_data_d[p*BITS +: BITS] = '0;
      rd_busy_d[p] = busy_d[bus.rd_addr[p*AW +: AW]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_busy  = rd_busy_q;
  assign bus.busy_any = busy_any;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed tests on the default register file plus a random sweep
// of a 16x64, 4-read, 1-write instance against a reference model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.BITS(32), .NREGS(32), .NRD(2), .NWR(2)) b0 ();
  regfile_mp_if #(.BITS(64), .NREGS(16), .NRD(4), .NWR(1)) b1 ();

  regfile_mp #(.BITS(32), .NREGS(32), .NRD(2), .NWR(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  regfile_mp #(.BITS(64), .NREGS(16), .NRD(4), .NWR(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle0;
    b0.rd_addr = '0;
    b0.wr_en   = '0;
    b0.wr_addr = '0;
    b0.wr_data = '0;
    b0.sb_set  = 1'b0;
    b0.sb_addr = '0;
  endtask

  task automatic idle1;
    b1.rd_addr = '0;
    b1.wr_en   = '0;
    b1.wr_addr = '0;
    b1.wr_data = '0;
    b1.sb_set  = 1'b0;
    b1.sb_addr = '0;
  endtask

  task automatic test_reset;
    idle0();
    idle1();
    rst = 1'b1;
    #12;
    checks++;
    if (b0.rd_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", b0.rd_data);
    end
    checks++;
    if (b0.rd_busy !== 2'b00 || b0.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b/%b want 00/0",
               b0.rd_busy, b0.busy_any);
    end
    @(negedge clk);
    rst = 1'b0;
    b0.wr_en   = 2'b01;
    b0.wr_addr = {5'd0, 5'd5};
    b0.wr_data = {32'h0, 32'hDEADBEEF};
    b0.sb_set  = 1'b1;
    b0.sb_addr = 5'd5;
    b0.rd_addr = {5'd0, 5'd5};
    tick();
    checks++;
    if (b0.rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pre_reset_write: got %h want deadbeef",
               b0.rd_data[31:0]);
    end
    checks++;
    if (b0.rd_busy[0] !== 1'b1 || b0.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy: got %b/%b want 1/1",
               b0.rd_busy[0], b0.busy_any);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (b0.rd_data !== 64'h0) begin
      errors++;
      $display("FAIL async_reset_data: got %h want 0", b0.rd_data);
    end
    checks++;
    if (b0.rd_busy !== 2'b00 || b0.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_busy: got %b/%b want 00/0",
               b0.rd_busy, b0.busy_any);
    end
    @(negedge clk);
    idle0();
    b0.rd_addr = {5'd5, 5'd5};
    rst = 1'b0;
    tick();
    checks++;
    if (b0.rd_data !== 64'h0 || b0.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL r5_after_reset: got %h/%b want 0/0",
               b0.rd_data, b0.busy_any);
    end
  endtask

  task automatic test_bypass;
    idle0();
    b0.wr_en   = 2'b01;
    b0.wr_addr = {5'd0, 5'd7};
    b0.wr_data = {32'h0, 32'h12345678};
    b0.rd_addr = {5'd7, 5'd7};
    tick();
    checks++;
    if (b0.rd_data !== {32'h12345678, 32'h12345678}) begin
      errors++;
      $display("FAIL bypass: got %h want 1234567812345678",
               b0.rd_data);
    end
    idle0();
    b0.rd_addr = {5'd0, 5'd7};
    tick();
    checks++;
    if (b0.rd_data !== {32'h0, 32'h12345678}) begin
      errors++;
      $display("FAIL stored_r7: got %h want 0000000012345678",
               b0.rd_data);
    end
  endtask

  task automatic test_conflict;
    idle0();
    b0.wr_en   = 2'b11;
    b0.wr_addr = {5'd3, 5'd3};
    b0.wr_data = {32'h0000BBBB, 32'hAAAA0000};
    b0.rd_addr = {5'd0, 5'd3};
    tick();
    checks++;
    if (b0.rd_data[31:0] !== 32'h0000BBBB) begin
      errors++;
      $display("FAIL conflict_bypass: got %h want 0000bbbb",
               b0.rd_data[31:0]);
    end
    idle0();
    b0.rd_addr = {5'd3, 5'd7};
    tick();
    checks++;
    if (b0.rd_data !== {32'h0000BBBB, 32'h12345678}) begin
      errors++;
      $display("FAIL conflict_stored: got %h want 0000bbbb12345678",
               b0.rd_data);
    end
  endtask

  task automatic test_x0;
    idle0();
    b0.wr_en   = 2'b11;
    b0.wr_addr = {5'd0, 5'd0};
    b0.wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    b0.sb_set  = 1'b1;
    b0.sb_addr = 5'd0;
    b0.rd_addr = {5'd0, 5'd0};
    tick();
    checks++;
    if (b0.rd_data !== 64'h0) begin
      errors++;
      $display("FAIL x0_bypass: got %h want 0", b0.rd_data);
    end
    checks++;
    if (b0.rd_busy !== 2'b00 || b0.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL x0_busy: got %b/%b want 00/0",
               b0.rd_busy, b0.busy_any);
    end
    idle0();
    tick();
    checks++;
    if (b0.rd_data !== 64'h0 || b0.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL x0_stored: got %h/%b want 0/0",
               b0.rd_data, b0.busy_any);
    end
  endtask

  task automatic test_scoreboard;
    idle0();
    b0.sb_set  = 1'b1;
    b0.sb_addr = 5'd9;
    b0.rd_addr = {5'd10, 5'd9};
    tick();
    checks++;
    if (b0.rd_busy !== 2'b01 || b0.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL sb_set: got %b/%b want 01/1",
               b0.rd_busy, b0.busy_any);
    end
    idle0();
    b0.wr_en   = 2'b10;
    b0.wr_addr = {5'd9, 5'd0};
    b0.wr_data = {32'h00000099, 32'h0};
    b0.rd_addr = {5'd10, 5'd9};
    tick();
    checks++;
    if (b0.rd_busy !== 2'b00 || b0.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: got %b/%b want 00/0",
               b0.rd_busy, b0.busy_any);
    end
    checks++;
    if (b0.rd_data[31:0] !== 32'h00000099) begin
      errors++;
      $display("FAIL sb_clear_data: got %h want 00000099",
               b0.rd_data[31:0]);
    end
    b0.wr_en   = 2'b01;
    b0.wr_addr = {5'd0, 5'd9};
    b0.wr_data = {32'h0, 32'h0000009A};
    b0.sb_set  = 1'b1;
    b0.sb_addr = 5'd9;
    tick();
    checks++;
    if (b0.rd_busy !== 2'b01 || b0.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins: got %b/%b want 01/1",
               b0.rd_busy, b0.busy_any);
    end
    b0.wr_en   = 2'b01;
    b0.wr_addr = {5'd0, 5'd9};
    b0.sb_addr = 5'd10;
    tick();
    checks++;
    if (b0.rd_busy !== 2'b10 || b0.busy_any !== 1'b1) begin
      errors++;
      $display("FAIL sb_swap: got %b/%b want 10/1",
               b0.rd_busy, b0.busy_any);
    end
    idle0();
    b0.wr_en   = 2'b10;
    b0.wr_addr = {5'd10, 5'd0};
    b0.rd_addr = {5'd10, 5'd9};
    tick();
    checks++;
    if (b0.rd_busy !== 2'b00 || b0.busy_any !== 1'b0) begin
      errors++;
      $display("FAIL sb_drain: got %b/%b want 00/0",
               b0.rd_busy, b0.busy_any);
    end
  endtask

  task automatic test_back_to_back;
    idle0();
    b0.wr_en   = 2'b01;
    b0.wr_addr = {5'd0, 5'd12};
    b0.wr_data = {32'h0, 32'h00000001};
    b0.rd_addr = {5'd12, 5'd12};
    tick();
    checks++;
    if (b0.rd_data !== {32'h1, 32'h1}) begin
      errors++;
      $display("FAIL b2b_first: got %h want 0000000100000001",
               b0.rd_data);
    end
    b0.wr_data = {32'h0, 32'h00000002};
    tick();
    checks++;
    if (b0.rd_data !== {32'h2, 32'h2}) begin
      errors++;
      $display("FAIL b2b_second: got %h want 0000000200000002",
               b0.rd_data);
    end
    idle0();
    b0.rd_addr = {5'd3, 5'd12};
    tick();
    checks++;
    if (b0.rd_data !== {32'h0000BBBB, 32'h2}) begin
      errors++;
      $display("FAIL b2b_stored: got %h want 0000bbbb00000002",
               b0.rd_data);
    end
  endtask

  task automatic test_sweep;
    logic [63:0]  mem  [16];
    logic [15:0]  busy;
    logic [255:0] exp_d;
    logic [3:0]   exp_b;
    logic [3:0]   wa, sa, ra;
    logic [63:0]  wd;
    logic         we, ss;
    for (int r = 0; r < 16; r++) mem[r] = '0;
    busy = '0;
    for (int c = 0; c < 10000; c++) begin
      we = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = {$urandom, $urandom};
      ss = ($urandom_range(0, 3) == 0);
      sa = 4'($urandom_range(0, 15));
      b1.wr_en   = we;
      b1.wr_addr = wa;
      b1.wr_data = wd;
      b1.sb_set  = ss;
      b1.sb_addr = sa;
      if (we && wa != 4'd0) mem[wa] = wd;
      if (we) busy[wa] = 1'b0;
      if (ss && sa != 4'd0) busy[sa] = 1'b1;
      for (int p = 0; p < 4; p++) begin
        ra = 4'($urandom_range(0, 15));
        b1.rd_addr[p*4 +: 4] = ra;
        exp_d[p*64 +: 64] = mem[ra];
        exp_b[p] = busy[ra];
      end
      tick();
      checks++;
      if (b1.rd_data !== exp_d) begin
        errors++;
        $display("FAIL sweep_data c=%0d: got %h want %h",
                 c, b1.rd_data, exp_d);
      end
      checks++;
      if (b1.rd_busy !== exp_b) begin
        errors++;
        $display("FAIL sweep_busy c=%0d: got %b want %b",
                 c, b1.rd_busy, exp_b);
      end
      checks++;
      if (b1.busy_any !== (|busy)) begin
        errors++;
        $display("FAIL sweep_any c=%0d: got %b want %b",
                 c, b1.busy_any, |busy);
      end
    end
    idle1();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core. It is the successor to the single-write, two-read register file and sits between decode, which reads operands and marks destinations busy, and writeback, which retires results. Adds a configurable number of read/write ports, write-first bypass into the registered read path, deterministic write-port priority, and a per-register busy scoreboard for hazard detection.

## Interface
- BITS, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- AW, $clog2(NREGS), register address width (derived; not overridden)
- NRD, 2, number of read ports (1–4)
- NWR, 2, number of write ports (1–2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses; port p at bits [p*AW +: AW]
- rd_data  out  NRD*BITS  registered read data per port
- rd_busy  out  NRD  registered busy flag of the register addressed on each port
- wr_en  in  NWR  write enable per write port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*BITS  write data
- sb_set  in  1  mark register sb_addr busy (destination issued)
- sb_addr  in  AW  scoreboard set address
- busy_any  out  1  registered OR of all busy bits

## Operation
- Storage: NREGS × BITS. Register 0 reads as 0, is never written, and is never busy.
- Write: on each edge, for each port w with wr_en[w] and wr_addr[w]≠0, register ← wr_data[w]. If both ports target the same address, port NWR-1 (the higher index) wins.
- Read: rd_data[p] captured each edge. Value is the post-write content of rd_addr[p]: a same-cycle write to that address is bypassed (write-first), using the winning port's data. rd_addr[p]=0 → 0.
- Scoreboard: busy[r] cleared by any enabled write to r; set by sb_set with sb_addr=r. Simultaneous set and clear of the same r → set wins (the new producer supersedes). sb_set to 0 has no effect.
- rd_busy[p] captured each edge from the next-state busy bit of rd_addr[p], consistent with the write-first data.
- busy_any = registered OR of the next-state busy vector.
- No internal FSM beyond the storage and scoreboard; all ports are independent every cycle. Back-to-back writes to one address are legal; the last one wins.

## Timing
- Read latency: 1 cycle. Address presented in cycle t → rd_data/rd_busy valid after edge t+1 and held until the next edge.
- Write visible to a same-cycle read (bypass) and to all later reads.
- Scoreboard set/clear visible on rd_busy/busy_any after the same edge.
- Reset (asynchronous assert, any time including mid-write): all registers 0, all busy 0, rd_data 0, rd_busy 0, busy_any 0, immediately. Writes and sets in the cycle reset is asserted are discarded. First post-reset edge behaves normally.

## Structure
- Package regfile_pkg: default BITS/NREGS, AW derivation function, and the x0 index constant (REG_ZERO = 0). Shared with decode and the hazard unit.
- One sub-module, regfile_scoreboard: the NREGS busy vector, set/clear priority and busy_any. The top module holds storage, write priority, bypass and output registers.

## Test plan
- Reset mid-operation: write 0xDEADBEEF to r5, assert rst asynchronously between edges → rd_data, rd_busy and busy_any are 0 at once; a read of r5 after reset returns 0.
- Bypass: in one cycle, write 0x12345678 to r7 on port 0 and read r7 on ports 0 and 1 → both rd_data = 0x12345678 after one edge.
- Write conflict: port 0 writes 0xAAAA0000 to r3 while port 1 writes 0x0000BBBB to r3 → a read of r3 returns 0x0000BBBB.
- x0: write 0xFFFFFFFF to r0 and sb_set r0 → a read of r0 gives 0 with rd_busy 0, and busy_any stays 0.
- Scoreboard: sb_set r9 → rd_busy=1 and busy_any=1; a write to r9 → rd_busy=0 and busy_any=0. A same-cycle write and sb_set on r9 → rd_busy=1.
- Parameter sweep: NREGS=16, BITS=64, NRD=4, NWR=1 → random read/write traffic matches a reference model for 10k cycles.
